// File: rtl/filter_dataflow_pkg.sv
// Shared definitions for the filter output dataflow: FSM state encoding and
// a width helper for counters and FIFO pointers.
package filter_dataflow_pkg;

    // Frame tracking states of the output side.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } fsm_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width able to hold 0..value-1, never narrower than one bit.
    function automatic int cnt_w(input int value);
        int w;
        w = clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/filter_dataflow_out_fifo.sv
// Synchronous FIFO holding {last, data} result entries. The caller only
// raises push_i when there is room (or a pop happens in the same cycle) and
// only raises pop_i when the FIFO is non-empty. The read port is a
// fall-through of the head entry and reads as zero while empty.
module sync_fifo
    import filter_dataflow_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [cnt_w(DEPTH):0]     count_o
);

    localparam int AW = cnt_w(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/filter_dataflow_out.sv
// Output side of the filter dataflow. Realigns the input pixel-valid to the
// filter core latency, tracks raster position, filters or zeroes 3x3 border
// pixels, queues {last, data} results in a FIFO for a valid/ready sink and
// reports end of frame.
// Build option: define BORDER_ZERO_EN to emit border positions as zero
// (WIDTH_IMG*HEIGHT_IMG outputs per frame); leave it undefined to drop them
// ((WIDTH_IMG-2)*(HEIGHT_IMG-2) outputs per frame).
//
// Handshake: an entry transfers on a cycle where data_valid_out and
// ready_out are both high at the rising edge; while data_valid_out is high
// and ready_out is low, data_out and last_out hold their value.
module filter_dataflow_out
    import filter_dataflow_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH_IMG  = 255,
    parameter int HEIGHT_IMG = 255,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pix_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  last_out,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [1:0]            fsm_state_o
);

    localparam int COL_W = cnt_w(WIDTH_IMG);
    localparam int ROW_W = cnt_w(HEIGHT_IMG);
    localparam int CNT_W = cnt_w(FIFO_DEPTH) + 1;
    localparam int EW    = DATA_WIDTH + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH_IMG - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_IMG - 1);
    localparam logic [COL_W-1:0] COL_PEN  = COL_W'(WIDTH_IMG - 2);
    localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(HEIGHT_IMG - 2);

    // ---------------- valid delay line ----------------
    logic [PIPE_LAT-1:0] vline_q, vline_d;
    logic                v_d;

    // Shift the input valid along only while the pipeline advances.
    always_comb begin
        vline_d = vline_q;
        if (enable) begin
            vline_d[0] = pix_valid_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vline_d[i] = vline_q[i-1];
            end
        end
    end

    // Delay line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vline_q <= '0;
        end else begin
            vline_q <= vline_d;
        end
    end

    assign v_d = vline_q[PIPE_LAT-1];

    // ---------------- raster counters ----------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             advance;
    logic             col_last, row_last, border;

    assign advance  = enable && v_d;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign border   = (row_q == '0) || row_last || (col_q == '0) || col_last;

    // Column runs across the row; row steps at end of row and both wrap at frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- write side ----------------
    logic                  wr_req;
    logic                  wr_last;
    logic [DATA_WIDTH-1:0] wr_data;

`ifdef BORDER_ZERO_EN
    // Every position is written; border positions carry zero.
    assign wr_req  = advance;
    assign wr_data = border ? '0 : data_in;
    assign wr_last = row_last && col_last;
`else
    // Only interior positions are written; the last one is the bottom-right interior pixel.
    assign wr_req  = advance && !border;
    assign wr_data = data_in;
    assign wr_last = (row_q == ROW_PEN) && (col_q == COL_PEN);
`endif

    // ---------------- FIFO ----------------
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [EW-1:0]    fifo_rdata;
    logic             pop, push_ok, drop;
    logic             head_last, pop_last, push_last;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop       = !fifo_empty && ready_out;
    assign push_ok   = wr_req && (!fifo_full || pop);
    assign drop      = wr_req && fifo_full && !pop;
    assign head_last = fifo_rdata[DATA_WIDTH];
    assign pop_last  = pop && head_last;
    assign push_last = push_ok && wr_last;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i ({wr_last, wr_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign data_out       = fifo_rdata[DATA_WIDTH-1:0];
    assign last_out       = head_last;
    assign data_valid_out = !fifo_empty;

    // ---------------- frame FSM ----------------
    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] lasts_q, lasts_d;
    logic [CNT_W-1:0] count_after;
    logic             frame_done_q, overflow_q;

    // lasts_q counts end-of-frame entries currently queued, so DRAIN knows
    // whether another frame's last entry is already waiting behind this one.
    always_comb begin
        lasts_d     = lasts_q + CNT_W'(push_last) - CNT_W'(pop_last);
        count_after = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
        state_d     = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push_last) begin
                    state_d = ST_DRAIN;
                end else if (push_ok) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (push_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_last) begin
                    if (lasts_d != '0) begin
                        state_d = ST_DRAIN;
                    end else if (count_after != '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, frame-done pulse and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lasts_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lasts_q      <= lasts_d;
            frame_done_q <= pop_last;
            overflow_q   <= overflow_q || drop;
        end
    end

    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_filter_dataflow_out.sv
// Bench for filter_dataflow_out at 4x4 frame, latency 3, FIFO depth 8.
// Works in both builds (BORDER_ZERO_EN defined or not).
module tb_filter_dataflow_out;
    import filter_dataflow_pkg::*;

    localparam int DW    = 8;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;
`ifdef BORDER_ZERO_EN
    localparam int NOUT     = 16;
    localparam int B2B_HOLD = 10;
    localparam int OVF_OUTS = 8;
    localparam int OVF_DONE = 0;
    localparam bit OVF_FLAG = 1'b1;
`else
    localparam int NOUT     = 4;
    localparam int B2B_HOLD = 44;
    localparam int OVF_OUTS = 4;
    localparam int OVF_DONE = 1;
    localparam bit OVF_FLAG = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          pix_valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready_out = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid_out, last_out, frame_done, overflow;
    logic [1:0]    fsm_state_o;

    always #5 clk = ~clk;

    filter_dataflow_out #(
        .DATA_WIDTH (DW),
        .WIDTH_IMG  (W),
        .HEIGHT_IMG (H),
        .PIPE_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pix_valid_in   (pix_valid_in),
        .data_in        (data_in),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .last_out       (last_out),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .fsm_state_o    (fsm_state_o)
    );

    // ---------------- bookkeeping ----------------
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic        cv [LAT];
    logic [7:0]  cd [LAT];
    logic        fd_prev, prev_v, prev_r, prev_l, saw_d2a;
    logic [7:0]  prev_d;
    logic [1:0]  prev_state;
    int          out_cnt, done_cnt;
    logic [8:0]  got [32];
    logic [8:0]  hand [16];

    typedef struct {
        int gap_at;
        int gap_len;
        bit sparse;
        int hold;
        bit toggle;
        int cap;
        int nframes;
        int exp_outs;
        int exp_done;
        bit exp_ovf;
        bit exp_d2a;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pix_val(input int f, input int r, input int c);
        return 8'(8'h81 + f * 64 + r * 16 + c);
    endfunction

    function automatic logic rdy_fn(input int t, input int hold, input bit toggle);
        if (t < hold) return 1'b0;
        if (toggle) return (t % 2) == 1;
        return 1'b1;
    endfunction

    // Expected FIFO entry for a pixel at (r,c); keep=0 when nothing is emitted.
    task automatic exp_entry(input int r, input int c, input logic [7:0] val,
                             output bit keep, output logic [8:0] e);
        bit brd;
        brd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
`ifdef BORDER_ZERO_EN
        keep = 1'b1;
        e    = {(r == H - 1) && (c == W - 1), brd ? 8'h00 : val};
`else
        keep = !brd;
        e    = {(r == H - 2) && (c == W - 2), val};
`endif
    endtask

    task automatic clear_models();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) begin
            cv[i] = 1'b0;
            cd[i] = 8'h00;
        end
        fd_prev    = 1'b0;
        prev_v     = 1'b0;
        prev_r     = 1'b0;
        prev_l     = 1'b0;
        prev_d     = 8'h00;
        prev_state = ST_IDLE;
        saw_d2a    = 1'b0;
        out_cnt    = 0;
        done_cnt   = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(data_valid_out), 32'(0));
        check({tag, "_data"}, 32'(data_out), 32'(0));
        check({tag, "_last"}, 32'(last_out), 32'(0));
        check({tag, "_done"}, 32'(frame_done), 32'(0));
        check({tag, "_ovf"}, 32'(overflow), 32'(0));
        check({tag, "_state"}, 32'(fsm_state_o), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        pix_valid_in = 1'b0;
        ready_out = 1'b0;
        data_in = 8'h00;
        #1;
        check_reset_values("rst");
        clear_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Observes outputs just ahead of the rising edge the inputs apply to.
    task automatic monitor();
        logic [8:0] e;
        logic       fd_next;
        fd_next = 1'b0;
        check("frame_done", 32'(frame_done), 32'(fd_prev));
        if (prev_v && !prev_r) begin
            check("hold_valid", 32'(data_valid_out), 32'(1));
            check("hold_data", 32'(data_out), 32'(prev_d));
            check("hold_last", 32'(last_out), 32'(prev_l));
        end
        if (data_valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_output got=%0h exp=none", {last_out, data_out});
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(data_out), 32'(e[7:0]));
                check("out_last", 32'(last_out), 32'(e[8]));
                fd_next = e[8];
            end
            if (out_cnt < 32) got[out_cnt] = {last_out, data_out};
            out_cnt++;
        end
        if (frame_done) done_cnt++;
        if (prev_state == ST_DRAIN && fsm_state_o == ST_ACTIVE) saw_d2a = 1'b1;
        prev_v     = data_valid_out;
        prev_r     = ready_out;
        prev_d     = data_out;
        prev_l     = last_out;
        prev_state = fsm_state_o;
        fd_prev    = fd_next;
    endtask

    // One clock: drive at the falling edge, observe, then advance the core model.
    task automatic tick(input logic en, input logic pv, input logic [7:0] pval, input logic rdy);
        @(negedge clk);
        enable       = en;
        pix_valid_in = pv;
        ready_out    = rdy;
        data_in      = cv[LAT-1] ? cd[LAT-1] : 8'hEE;
        #1;
        monitor();
        @(posedge clk);
        if (en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                cv[i] = cv[i-1];
                cd[i] = cd[i-1];
            end
            cv[0] = pv;
            cd[0] = pval;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         p, t, f, r, c, bound;
        logic       en, pv;
        logic [7:0] val;
        logic [8:0] e;
        bit         keep;
        string      tag;
        tag = $sformatf("row%0d", idx);
        p = 0;
        t = 0;
        while (p < 16 * v.nframes) begin
            en  = !(v.gap_len > 0 && t >= v.gap_at && t < v.gap_at + v.gap_len);
            pv  = en && (!v.sparse || (t % 2) == 0);
            val = 8'hEE;
            if (pv) begin
                f   = p / 16;
                r   = (p % 16) / W;
                c   = p % W;
                val = pix_val(f, r, c);
                exp_entry(r, c, val, keep, e);
                if (keep && (v.cap == 0 || exp_q.size() < v.cap)) exp_q.push_back(e);
                p++;
            end
            tick(en, pv, val, rdy_fn(t, v.hold, v.toggle));
            t++;
        end
        bound = 0;
        while (exp_q.size() != 0 && bound < 300) begin
            tick(1'b1, 1'b0, 8'hEE, rdy_fn(t, v.hold, v.toggle));
            t++;
            bound++;
        end
        if (bound >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=%0d exp=0 pending", tag, exp_q.size());
        end
        repeat (3) tick(1'b1, 1'b0, 8'hEE, 1'b1);
        check({tag, "_outs"}, 32'(out_cnt), 32'(v.exp_outs));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(v.exp_done));
        check({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
        check({tag, "_end_state"}, 32'(fsm_state_o),
              32'((v.exp_done == v.nframes) ? ST_IDLE : ST_ACTIVE));
        if (v.exp_d2a) check({tag, "_drain_to_active"}, 32'(saw_d2a), 32'(1));
        if (v.nframes == 1) begin
            for (int i = 0; i < v.exp_outs && i < out_cnt; i++) begin
                check($sformatf("%s_hand%0d", tag, i), 32'(got[i]), 32'(hand[i]));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Hand-computed output sequence of one frame (frame index 0).
`ifdef BORDER_ZERO_EN
        hand = '{9'h000, 9'h000, 9'h000, 9'h000,
                 9'h000, 9'h092, 9'h093, 9'h000,
                 9'h000, 9'h0A2, 9'h0A3, 9'h000,
                 9'h000, 9'h000, 9'h000, 9'h100};
`else
        hand = '{9'h092, 9'h093, 9'h0A2, 9'h1A3,
                 9'h000, 9'h000, 9'h000, 9'h000,
                 9'h000, 9'h000, 9'h000, 9'h000,
                 9'h000, 9'h000, 9'h000, 9'h000};
`endif
        //           gap_at gap_len sparse hold      toggle cap    nfr outs      done      ovf       d2a
        vecs[0] = '{0,     0,      1'b0,  0,        1'b0,  0,     1,  NOUT,     1,        1'b0,     1'b0};
        vecs[1] = '{6,     5,      1'b0,  0,        1'b0,  0,     1,  NOUT,     1,        1'b0,     1'b0};
        vecs[2] = '{0,     0,      1'b0,  9,        1'b0,  0,     1,  NOUT,     1,        1'b0,     1'b0};
        vecs[3] = '{0,     0,      1'b1,  0,        1'b1,  0,     1,  NOUT,     1,        1'b0,     1'b0};
        vecs[4] = '{0,     0,      1'b0,  30,       1'b0,  DEPTH, 1,  OVF_OUTS, OVF_DONE, OVF_FLAG, 1'b0};
        vecs[5] = '{0,     0,      1'b1,  B2B_HOLD, 1'b1,  0,     2,  2 * NOUT, 2,        1'b0,     1'b1};

        clear_models();
        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_vec(vecs[i], i);
        end

        // Asynchronous reset in the middle of a frame with results queued.
        do_reset();
        for (int p = 0; p < 12; p++) begin
            tick(1'b1, 1'b1, pix_val(0, p / W, p % W), 1'b0);
        end
        #1;
        check("pre_rst_valid", 32'(data_valid_out), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        clear_models();
        enable = 1'b0;
        pix_valid_in = 1'b0;
        ready_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Restarted frame must again begin at row 0, column 0.
        run_vec(vecs[0], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
